// File: rtl/uart_rx_deserializer.sv
// Purpose: asynchronous serial receiver, 8N1/8E1/8O1 frames reassembled into parallel bytes.
// Latency: rx_interrupt rises 2 sync + HALF + (DATA_WIDTH+1+PARITY_EN)*CLKS_PER_BIT + 1 cycles after the start edge.
// Backpressure: none; the one-cycle rx_interrupt must be latched downstream (flag register).
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 434,  // >= 4
  parameter int DATA_WIDTH   = 8,    // >= 2
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_interrupt,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // Last count of the half-bit start qualification and of a full bit period.
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic             HAS_PAR  = (PARITY_EN != 0);
  localparam logic             ODD_PAR  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t                r_state;
  logic                  r_sync1;
  logic                  r_sync2;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_perr;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_irq;
  logic                  r_perr_out;
  logic                  r_ferr_out;

  logic                  w_rx_s;
  logic                  w_bit_end;
  logic                  w_half_end;
  logic                  w_perr_now;

  assign w_rx_s     = r_sync2;
  assign w_bit_end  = (r_cnt == BIT_M1);
  assign w_half_end = (r_cnt == HALF_M1);
  // Parity check: data XOR received parity bit must equal the configured sense.
  assign w_perr_now = ((^r_shift) ^ w_rx_s) != ODD_PAR;

  // Two-flop synchronizer for the asynchronous line; resets to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM: start qualification, mid-bit sampling, result register and break hold-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_rx_data  <= '0;
      r_irq      <= 1'b0;
      r_perr_out <= 1'b0;
      r_ferr_out <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_perr  <= 1'b0;
          end
        end

        S_START: begin
          if (w_half_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            // A line back high at mid start bit is a glitch, not a frame.
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            // LSB arrives first, so shifting in at the top leaves it at bit 0.
            r_shift <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_state <= HAS_PAR ? S_PARITY : S_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_perr  <= w_perr_now;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_cnt      <= '0;
            r_rx_data  <= r_shift;
            r_perr_out <= r_perr;
            r_ferr_out <= ~w_rx_s;
            // Pulse even on error so the flag register always sees the frame.
            r_irq      <= 1'b1;
            r_state    <= w_rx_s ? S_IDLE : S_WAIT_HIGH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_WAIT_HIGH: begin
          // A held-low line (break) must not decode as back-to-back frames.
          if (w_rx_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_interrupt  = r_irq;
  assign parity_error  = r_perr_out;
  assign framing_error = r_ferr_out;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Asynchronous serial receiver for the P03 UART path: 8N1/8E1/8O1 frames arrive on the serial pin and are reassembled into parallel bytes.
- Emits a single-cycle rx_interrupt per completed frame, with the byte and error flags valid on that cycle.
- Sits directly upstream of the interrupt flag register, which latches rx_interrupt until software clears it.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); must be >= 4.
- DATA_WIDTH, 8, data bits per frame, LSB first.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- rx  input  1  serial line, asynchronous to clk, idles high.
- rx_data  output  DATA_WIDTH  last received byte; held until the next frame completes.
- rx_interrupt  output  1  one-cycle pulse when a frame completes.
- parity_error  output  1  parity mismatch on the last frame; 0 when PARITY_EN = 0.
- framing_error  output  1  stop bit sampled low on the last frame.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst = 1, async):
  - state = IDLE; synchronizer flops = 1; counters = 0.
  - rx_data = 0; rx_interrupt = 0; parity_error = 0; framing_error = 0; busy = 0.
  - Reset asserted mid-frame aborts the frame with no pulse; outputs return to reset values.
- Synchronizer: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- HALF = CLKS_PER_BIT/2 (integer division). Bit counter width is ceil(log2(CLKS_PER_BIT)).
- IDLE:
  - rx_s = 0 -> START, bit counter cleared. Call this cycle t0.
- START:
  - Counts HALF cycles.
  - At count HALF-1: rx_s = 0 -> DATA with counter cleared; rx_s = 1 -> IDLE (glitch rejected, no pulse, outputs unchanged).
- DATA:
  - Counts CLKS_PER_BIT cycles per bit; samples rx_s at count CLKS_PER_BIT-1.
  - Sample shifts into the MSB of the shift register (LSB-first reassembly); bit index increments.
  - After DATA_WIDTH samples -> PARITY if PARITY_EN, else STOP.
  - Bit i (0-based) is sampled at t0 + HALF + (i+1)*CLKS_PER_BIT.
- PARITY:
  - One bit period; sample at the end.
  - perr = (XOR of data bits XOR sampled bit) != PARITY_ODD.
- STOP:
  - One bit period; sample at the end, at cycle ts = t0 + HALF + (DATA_WIDTH+1+PARITY_EN)*CLKS_PER_BIT.
  - On cycle ts+1: rx_data = shift register; parity_error = perr; framing_error = ~stop_sample; rx_interrupt = 1 for exactly that cycle.
  - Stop sample = 1 -> IDLE.
  - Stop sample = 0 -> WAIT_HIGH.
  - rx_interrupt fires even on error, so the flag register is always notified.
- WAIT_HIGH:
  - Stays until rx_s = 1, then -> IDLE. Prevents a held-low line (break) from being decoded as repeated frames.
- Error flags and rx_data update only on the rx_interrupt cycle and are otherwise stable.
- Back-to-back frames: a start edge arriving in the cycle after the STOP -> IDLE transition is accepted normally. No dead time beyond the 1-cycle IDLE visit.
- rx_interrupt is never high on two consecutive cycles.

Test Plan:
- CLKS_PER_BIT = 8, PARITY_EN = 0, send 0xA5 (8N1):
  - rx_data = 0xA5, errors = 0.
  - One pulse at pin-edge + 2 + 4 + 9*8 + 1 = pin-edge + 79 cycles.
  - busy high from t0 until return to IDLE.
- PARITY_EN = 1, PARITY_ODD = 0:
  - Send 0x3C with parity 0 -> parity_error = 0.
  - Resend with parity 1 -> parity_error = 1, rx_data = 0x3C, pulse still fires.
- Stop bit forced low on byte 0x55, then rx held low 40 cycles:
  - framing_error = 1, exactly one pulse.
  - FSM in WAIT_HIGH; no second frame until rx returns high.
- 2-cycle low glitch on an idle line:
  - Returns to IDLE from START; no pulse; rx_data unchanged.
- Two frames 0x00 then 0xFF back-to-back, no idle gap:
  - Two pulses, rx_data = 0x00 then 0xFF, no errors.
- rst asserted for 3 cycles at the middle of data bit 4:
  - All outputs 0 immediately (async).
  - The next full frame 0x81 is received correctly.
